// File: rtl/coef_dezigzag_feeder.sv
// coef_dezigzag_feeder: ping-pong 8x8 coefficient buffer. Coefficients arrive
// in zigzag order and leave in row-major (natural) order for the row IDCT.
// Ports:
//   clk, rst_b        - clock, synchronous active-high reset
//   in_valid/in_ready - input handshake; in_coef signed 16-bit, zigzag order
//   in_mode           - block mode, sampled with the first coefficient
//   in_eob            - early end-of-block (only with COEF_ZERO_FILL_EN)
//   data_out          - natural-order coefficient, one per cycle, no backpressure
//   out_mode_flag     - mode of the block being streamed
//   output_start      - one-cycle pulse with element 0 of each block
// Optional feature: define COEF_ZERO_FILL_EN to enable in_eob with zero fill
// of the coefficient positions that were never written.
module coef_dezigzag_feeder (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_coef,
  input  logic        in_mode,
`ifdef COEF_ZERO_FILL_EN
  input  logic        in_eob,
`endif
  output logic [15:0] data_out,
  output logic        out_mode_flag,
  output logic        output_start
);

  localparam int unsigned CW = 16;
  localparam int unsigned NW = 6;
  localparam logic [NW-1:0] LAST = NW'(63);

  // Zigzag position k -> natural (row-major) index.
  localparam logic [NW-1:0] ZZ_TAB [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   mem [128];
  logic [1:0]      full_q, full_d;
  logic [1:0]      mode_q;
  logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [NW-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic            accept_c, wr_done_c, emit_c, emit_first_c, release_c;
  logic [NW-1:0]   wr_nat_c;
  logic [CW-1:0]   rd_word_c;

  assign accept_c     = in_valid & in_ready;
  assign wr_nat_c     = ZZ_TAB[wr_cnt_q];
  assign emit_first_c = emit_c & (rd_cnt_q == '0);

`ifdef COEF_ZERO_FILL_EN
  logic [63:0] mask_q [2];

  assign wr_done_c = accept_c & ((wr_cnt_q == LAST) | in_eob);
  assign rd_word_c = mask_q[rd_bank_q][rd_cnt_q] ? mem[{rd_bank_q, rd_cnt_q}] : '0;

  // Written-position mask; cleared when the reader releases the bank.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      mask_q[0] <= '0;
      mask_q[1] <= '0;
    end else begin
      if (release_c) mask_q[rd_bank_q] <= '0;
      if (accept_c)  mask_q[wr_bank_q][wr_nat_c] <= 1'b1;
    end
  end
`else
  assign wr_done_c = accept_c & (wr_cnt_q == LAST);
  assign rd_word_c = mem[{rd_bank_q, rd_cnt_q}];
`endif

  // Writer: count coefficients, flip bank on block completion.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (wr_done_c) begin
      wr_cnt_d  = '0;
      wr_bank_d = ~wr_bank_q;
    end else if (accept_c) begin
      wr_cnt_d  = wr_cnt_q + NW'(1);
    end
  end

  // Reader FSM. IDLE launches element 0 on the same edge it leaves, so the
  // first output appears two cycles after the last accepted coefficient.
  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    emit_c    = 1'b0;
    release_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          emit_c   = 1'b1;
          rd_cnt_d = rd_cnt_q + NW'(1);
          state_d  = STREAM;
        end
      end
      STREAM: begin
        emit_c   = 1'b1;
        rd_cnt_d = rd_cnt_q + NW'(1);
        if (rd_cnt_q == LAST) begin
          release_c = 1'b1;
          rd_bank_d = ~rd_bank_q;
          state_d   = full_q[~rd_bank_q] ? STREAM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Full flags: reader release and writer completion never hit the same bank.
  always_comb begin
    full_d = full_q;
    if (release_c) full_d[rd_bank_q] = 1'b0;
    if (wr_done_c) full_d[wr_bank_q] = 1'b1;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q       <= IDLE;
      full_q        <= '0;
      mode_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      in_ready      <= 1'b1;
      data_out      <= '0;
      out_mode_flag <= 1'b0;
      output_start  <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      in_ready     <= ~full_d[wr_bank_d];
      data_out     <= emit_c ? rd_word_c : '0;
      output_start <= emit_first_c;
      if (accept_c && (wr_cnt_q == '0)) mode_q[wr_bank_q] <= in_mode;
      if (emit_first_c) out_mode_flag <= mode_q[rd_bank_q];
    end
  end

  // Coefficient storage: bank bit on top, natural index below.
  always_ff @(posedge clk) begin
    if (accept_c) mem[{wr_bank_q, wr_nat_c}] <= in_coef;
  end

endmodule

// File: tb/tb_coef_dezigzag_feeder.sv
// Directed bench for coef_dezigzag_feeder. Expected natural-order data comes
// from a zigzag table the bench builds by walking anti-diagonals.
module tb_coef_dezigzag_feeder;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_coef;
  logic        in_mode;
`ifdef COEF_ZERO_FILL_EN
  logic        in_eob;
`endif
  logic [15:0] data_out;
  logic        out_mode_flag;
  logic        output_start;

  coef_dezigzag_feeder dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_coef      (in_coef),
    .in_mode      (in_mode),
`ifdef COEF_ZERO_FILL_EN
    .in_eob       (in_eob),
`endif
    .data_out     (data_out),
    .out_mode_flag(out_mode_flag),
    .output_start (output_start)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_acc_cyc = 0;
  int          stall_n = 0;
  int          start_q[$];
  logic [15:0] cap_d[$];
  logic        cap_m[$];
  bit          capturing = 1'b0;
  int          pos = 0;
  int          zz[64];
  logic [15:0] blk[64];
  logic [15:0] expv[64];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: a block is the output_start cycle plus the next 63.
  always @(negedge clk) begin
    if (rst_b) begin
      capturing = 1'b0;
    end else begin
      if (in_valid && in_ready) last_acc_cyc = cyc;
      if (!in_ready) stall_n++;
      if (output_start) begin
        start_q.push_back(cyc);
        pos = 0;
        capturing = 1'b1;
      end else if (capturing && pos < 63) begin
        pos++;
      end else begin
        capturing = 1'b0;
      end
      if (capturing) begin
        cap_d.push_back(data_out);
        cap_m.push_back(out_mode_flag);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one coefficient and hold it until accepted (bounded).
  task automatic put(input logic [15:0] c, input logic m, input logic e);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_coef  = c;
    in_mode  = m;
`ifdef COEF_ZERO_FILL_EN
    in_eob   = e;
`else
    if (e) guard = 0;
`endif
    @(negedge clk);
    while (!in_ready && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 300) chk("put_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
`ifdef COEF_ZERO_FILL_EN
    in_eob   = 1'b0;
`endif
  endtask

  task automatic send_block(input logic m, input bit gaps);
    for (int k = 0; k < 64; k++) begin
      if (gaps && $urandom_range(1, 0) == 1) idle(1);
      put(blk[k], m, 1'b0);
    end
  endtask

  task automatic build_exp();
    for (int k = 0; k < 64; k++) expv[zz[k]] = blk[k];
  endtask

  task automatic wait_caps(input int n);
    int guard;
    guard = 0;
    while (cap_d.size() < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("capture_count", 32'(cap_d.size() >= n), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_block(input string tag, input int base, input logic m);
    logic [15:0] d;
    logic        mm;
    for (int n = 0; n < 64; n++) begin
      d  = (base + n < cap_d.size()) ? cap_d[base + n] : 16'hxxxx;
      mm = (base + n < cap_m.size()) ? cap_m[base + n] : 1'bx;
      chk($sformatf("%s_data[%0d]", tag, n), 32'(d), 32'(expv[n]));
      chk($sformatf("%s_mode[%0d]", tag, n), 32'(mm), 32'(m));
    end
  endtask

  task automatic clear_caps();
    cap_d.delete();
    cap_m.delete();
    start_q.delete();
  endtask

  initial begin
    int idx, lo, hi;
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz[idx] = r * 8 + (s - r);
          idx++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz[idx] = r * 8 + (s - r);
          idx++;
        end
      end
    end

    rst_b = 1'b1;
    in_valid = 1'b0;
    in_coef = '0;
    in_mode = 1'b0;
`ifdef COEF_ZERO_FILL_EN
    in_eob = 1'b0;
`endif
    idle(3);
    rst_b = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_mode", 32'(out_mode_flag), 32'd0);
    chk("rst_start", 32'(output_start), 32'd0);

    // Single block, coef = k, mode 1.
    for (int k = 0; k < 64; k++) blk[k] = 16'(k);
    build_exp();
    send_block(1'b1, 1'b0);
    wait_caps(64);
    check_block("blk1", 0, 1'b1);
    chk("blk1_n1", 32'(cap_d[1]), 32'd1);
    chk("blk1_n8", 32'(cap_d[8]), 32'd2);
    chk("blk1_n63", 32'(cap_d[63]), 32'd63);
    chk("blk1_latency", 32'(start_q[0] - last_acc_cyc), 32'd2);
    idle(2);
    chk("idle_data", 32'(data_out), 32'd0);
    chk("idle_start", 32'(output_start), 32'd0);
    chk("idle_mode_hold", 32'(out_mode_flag), 32'd1);

    // Three back-to-back blocks, modes 0/1/0.
    clear_caps();
    stall_n = 0;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 64; k++) blk[k] = 16'(b * 64 + k);
      send_block(1'(b % 2), 1'b0);
    end
    wait_caps(192);
    chk("b2b_starts", 32'(start_q.size()), 32'd3);
    chk("b2b_gap1", 32'(start_q[1] - start_q[0]), 32'd64);
    chk("b2b_gap2", 32'(start_q[2] - start_q[0]), 32'd128);
    chk("b2b_no_stall", 32'(stall_n), 32'd0);
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 64; k++) blk[k] = 16'(b * 64 + k);
      build_exp();
      check_block($sformatf("b2b%0d", b), b * 64, 1'(b % 2));
    end

    // Same random block gap-free, then with ~50% input gaps.
    for (int k = 0; k < 64; k++) blk[k] = 16'($urandom);
    build_exp();
    for (int g = 0; g < 2; g++) begin
      clear_caps();
      send_block(1'b0, g == 1);
      wait_caps(64);
      check_block(g == 1 ? "gaps" : "nogaps", 0, 1'b0);
      chk("gaps_latency", 32'(start_q[0] - last_acc_cyc), 32'd2);
    end

    // Reset after 30 coefficients, then a full 0x7FFF block.
    clear_caps();
    for (int k = 0; k < 30; k++) put(16'h1234 + 16'(k), 1'b0, 1'b0);
    rst_b = 1'b1;
    idle(2);
    rst_b = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_mode", 32'(out_mode_flag), 32'd0);
    for (int k = 0; k < 64; k++) blk[k] = 16'h7FFF;
    build_exp();
    send_block(1'b1, 1'b0);
    wait_caps(64);
    check_block("after_rst", 0, 1'b1);
    idle(70);
    chk("after_rst_one_block", 32'(start_q.size()), 32'd1);

`ifdef COEF_ZERO_FILL_EN
    // Short blocks closed by in_eob; unwritten positions read as zero.
    clear_caps();
    stall_n = 0;
    put(16'd100, 1'b0, 1'b0);
    put(16'hFFFB, 1'b0, 1'b0);
    put(16'd7, 1'b0, 1'b1);
    put(16'h0011, 1'b1, 1'b1);
    put(16'h0022, 1'b0, 1'b1);
    put(16'h0033, 1'b1, 1'b1);
    wait_caps(256);
    chk("zf_stall", 32'(stall_n > 0), 32'd1);
    for (int i = 1; i < 4; i++)
      chk("zf_contig", 32'(start_q[i] - start_q[i-1]), 32'd64);
    for (int n = 0; n < 64; n++) expv[n] = '0;
    expv[0] = 16'd100;
    expv[1] = 16'hFFFB;
    expv[8] = 16'd7;
    check_block("zf_a", 0, 1'b0);
    for (int b = 1; b < 4; b++) begin
      for (int n = 0; n < 64; n++) expv[n] = '0;
      expv[0] = 16'(b * 17);
      check_block($sformatf("zf_%0d", b), b * 64, 1'(b % 2));
    end
`endif

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
